// File: rtl/register_file_pkg.sv
`default_nettype none
// ============================================================================
// Module : register_file_pkg
// Brief  : Shared CPU constants and helpers for the architectural register file.
// Rev    : 1.0
// ============================================================================
package register_file_pkg;

    localparam int ROB_WIDTH     = 4;
    localparam int REG_COUNT     = 32;
    localparam int REG_IDX_WIDTH = 5;
    localparam int DATA_WIDTH    = 32;
    localparam int COUNT_WIDTH   = 6;
    localparam logic [REG_IDX_WIDTH-1:0] ZERO_REG = 5'd0;

    // x0 is never busy, so only bits 31:1 are counted.
    function automatic logic [COUNT_WIDTH-1:0] busyPopcount(input logic [REG_COUNT-1:0] busyVec);
        logic [COUNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 1; i < REG_COUNT; i++) begin
            cnt = cnt + {{(COUNT_WIDTH-1){1'b0}}, busyVec[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module : register_file_if
// Brief  : Commit / rename / read bundle of the architectural register file.
// Rev    : 1.0
// ============================================================================
interface register_file_if #(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH
);
    import register_file_pkg::*;

    logic                      clear;
    logic                      commitValid;
    logic [REG_IDX_WIDTH-1:0]  commitDest;
    logic [DATA_WIDTH-1:0]     commitValue;
    logic [ROB_WIDTH-1:0]      commitRobId;
    logic                      renameValid;
    logic [REG_IDX_WIDTH-1:0]  renameDest;
    logic [ROB_WIDTH-1:0]      renameRobId;
    logic [REG_IDX_WIDTH-1:0]  rs1;
    logic [REG_IDX_WIDTH-1:0]  rs2;
    logic                      rs1Busy;
    logic                      rs2Busy;
    logic [ROB_WIDTH-1:0]      rs1Dep;
    logic [ROB_WIDTH-1:0]      rs2Dep;
    logic [DATA_WIDTH-1:0]     rs1Value;
    logic [DATA_WIDTH-1:0]     rs2Value;
    logic [COUNT_WIDTH-1:0]    busyCount;

    modport master (
        output clear, commitValid, commitDest, commitValue, commitRobId,
        output renameValid, renameDest, renameRobId, rs1, rs2,
        input  rs1Busy, rs2Busy, rs1Dep, rs2Dep, rs1Value, rs2Value, busyCount
    );

    modport slave (
        input  clear, commitValid, commitDest, commitValue, commitRobId,
        input  renameValid, renameDest, renameRobId, rs1, rs2,
        output rs1Busy, rs2Busy, rs1Dep, rs2Dep, rs1Value, rs2Value, busyCount
    );

endinterface
`default_nettype wire

// File: rtl/register_file_read_port.sv
`default_nettype none
// ============================================================================
// Module : RegisterReadPort
// Brief  : One source-operand read port with same-cycle commit bypass.
// Rev    : 1.0
// ============================================================================
module RegisterReadPort #(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH
) (
    input  wire logic [4:0]           rs,
    input  wire logic [31:0]          entryValue,
    input  wire logic                 entryBusy,
    input  wire logic [ROB_WIDTH-1:0] entryTag,
    input  wire logic                 commitValid,
    input  wire logic [4:0]           commitDest,
    input  wire logic [31:0]          commitValue,
    input  wire logic [ROB_WIDTH-1:0] commitRobId,
    output logic                      busy,
    output logic [ROB_WIDTH-1:0]      dep,
    output logic [31:0]               value
);
    import register_file_pkg::*;

    logic w_bypass;

    // Only the producer the entry is actually waiting on may forward its data.
    assign w_bypass = commitValid && (commitDest == rs) && (rs != ZERO_REG)
                      && entryBusy && (entryTag == commitRobId);

    assign busy  = entryBusy && !w_bypass;
    assign dep   = entryTag;
    assign value = w_bypass ? commitValue : entryValue;

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module : register_file
// Brief  : 32-entry architectural register file with ROB busy/tag tracking.
// Rev    : 1.0
// ============================================================================
module register_file #(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH
) (
    input  wire logic       clockIn,
    input  wire logic       resetIn,
    register_file_if.slave  bus
);
    import register_file_pkg::*;

    logic [DATA_WIDTH-1:0]  r_value [REG_COUNT];
    logic [ROB_WIDTH-1:0]   r_tag   [REG_COUNT];
    logic [REG_COUNT-1:0]   r_busy;
    logic [COUNT_WIDTH-1:0] r_busyCount;

    logic                   w_commitHit;
    logic                   w_renameHit;
    logic [REG_COUNT-1:0]   w_nextBusy;

    assign w_commitHit = bus.commitValid && (bus.commitDest != ZERO_REG);
    assign w_renameHit = bus.renameValid && (bus.renameDest != ZERO_REG) && !bus.clear;

    // Priority: matching commit frees, flush wipes, rename claims last so it wins.
    always_comb begin
        w_nextBusy = r_busy;
        if (w_commitHit && r_busy[bus.commitDest] && (r_tag[bus.commitDest] == bus.commitRobId)) begin
            w_nextBusy[bus.commitDest] = 1'b0;
        end
        if (bus.clear) begin
            w_nextBusy = '0;
        end
        if (w_renameHit) begin
            w_nextBusy[bus.renameDest] = 1'b1;
        end
        w_nextBusy[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy      <= '0;
            r_busyCount <= '0;
        end else begin
            if (w_commitHit) begin
                r_value[bus.commitDest] <= bus.commitValue;
            end
            if (w_renameHit) begin
                r_tag[bus.renameDest] <= bus.renameRobId;
            end
            r_busy      <= w_nextBusy;
            r_busyCount <= busyPopcount(w_nextBusy);
        end
    end

    assign bus.busyCount = r_busyCount;

    RegisterReadPort #(.ROB_WIDTH(ROB_WIDTH)) u_rs1Port (
        .rs          (bus.rs1),
        .entryValue  (r_value[bus.rs1]),
        .entryBusy   (r_busy[bus.rs1]),
        .entryTag    (r_tag[bus.rs1]),
        .commitValid (bus.commitValid),
        .commitDest  (bus.commitDest),
        .commitValue (bus.commitValue),
        .commitRobId (bus.commitRobId),
        .busy        (bus.rs1Busy),
        .dep         (bus.rs1Dep),
        .value       (bus.rs1Value)
    );

    RegisterReadPort #(.ROB_WIDTH(ROB_WIDTH)) u_rs2Port (
        .rs          (bus.rs2),
        .entryValue  (r_value[bus.rs2]),
        .entryBusy   (r_busy[bus.rs2]),
        .entryTag    (r_tag[bus.rs2]),
        .commitValid (bus.commitValid),
        .commitDest  (bus.commitDest),
        .commitValue (bus.commitValue),
        .commitRobId (bus.commitRobId),
        .busy        (bus.rs2Busy),
        .dep         (bus.rs2Dep),
        .value       (bus.rs2Value)
    );

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module : tb_register_file
// Brief  : Directed self-checking bench for register_file.
// Rev    : 1.0
// ============================================================================
module tb_register_file;

    logic clockIn;
    logic resetIn;
    int   checks;
    int   errors;

    register_file_if #(.ROB_WIDTH(4)) rfBus ();

    register_file #(.ROB_WIDTH(4)) dut (
        .clockIn (clockIn),
        .resetIn (resetIn),
        .bus     (rfBus)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clockIn);
        #1;
    endtask

    task automatic idle();
        rfBus.clear       = 1'b0;
        rfBus.commitValid = 1'b0;
        rfBus.commitDest  = '0;
        rfBus.commitValue = '0;
        rfBus.commitRobId = '0;
        rfBus.renameValid = 1'b0;
        rfBus.renameDest  = '0;
        rfBus.renameRobId = '0;
    endtask

    task automatic rename(input logic [4:0] dest, input logic [3:0] tag);
        rfBus.renameValid = 1'b1;
        rfBus.renameDest  = dest;
        rfBus.renameRobId = tag;
    endtask

    task automatic commit(input logic [4:0] dest, input logic [3:0] tag, input logic [31:0] val);
        rfBus.commitValid = 1'b1;
        rfBus.commitDest  = dest;
        rfBus.commitRobId = tag;
        rfBus.commitValue = val;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        resetIn = 1'b0;
        idle();
        rfBus.rs1 = 5'd5;
        rfBus.rs2 = 5'd0;
        repeat (2) tick();

        check("reset_rs1Busy",   {31'd0, rfBus.rs1Busy}, 32'd0);
        check("reset_rs1Dep",    {28'd0, rfBus.rs1Dep},  32'd0);
        check("reset_rs1Value",  rfBus.rs1Value,         32'd0);
        check("reset_busyCount", {26'd0, rfBus.busyCount}, 32'd0);

        resetIn = 1'b1;
        tick();

        // rename x5 tag 3
        rename(5'd5, 4'd3);
        tick();
        idle();
        check("ren_rs1Busy",   {31'd0, rfBus.rs1Busy}, 32'd1);
        check("ren_rs1Dep",    {28'd0, rfBus.rs1Dep},  32'd3);
        check("ren_busyCount", {26'd0, rfBus.busyCount}, 32'd1);

        // matching commit bypasses in the same cycle
        commit(5'd5, 4'd3, 32'hDEADBEEF);
        #1;
        check("byp_rs1Busy",  {31'd0, rfBus.rs1Busy}, 32'd0);
        check("byp_rs1Value", rfBus.rs1Value,         32'hDEADBEEF);
        tick();
        idle();
        check("cmt_busyCount", {26'd0, rfBus.busyCount}, 32'd0);
        check("cmt_rs1Value",  rfBus.rs1Value,          32'hDEADBEEF);

        // stale commit: value written, younger tag keeps x5 busy
        rename(5'd5, 4'd7);
        tick();
        idle();
        commit(5'd5, 4'd3, 32'h11);
        #1;
        check("stale_noByp_busy", {31'd0, rfBus.rs1Busy}, 32'd1);
        tick();
        idle();
        check("stale_rs1Busy",   {31'd0, rfBus.rs1Busy}, 32'd1);
        check("stale_rs1Dep",    {28'd0, rfBus.rs1Dep},  32'd7);
        check("stale_busyCount", {26'd0, rfBus.busyCount}, 32'd1);

        // commit and rename on x6 together: rename owns busy/tag
        rfBus.rs2 = 5'd6;
        commit(5'd6, 4'd2, 32'h66);
        rename(5'd6, 4'd9);
        tick();
        idle();
        check("same_rs2Busy",   {31'd0, rfBus.rs2Busy}, 32'd1);
        check("same_rs2Dep",    {28'd0, rfBus.rs2Dep},  32'd9);
        check("same_busyCount", {26'd0, rfBus.busyCount}, 32'd2);

        for (int r = 1; r <= 4; r++) begin
            rename(5'(r), 4'(r));
            tick();
        end
        idle();
        check("x1x4_busyCount", {26'd0, rfBus.busyCount}, 32'd6);

        // flush with concurrent rename x8 (dropped) and commit x7 (kept)
        rfBus.clear = 1'b1;
        rename(5'd8, 4'd5);
        commit(5'd7, 4'd1, 32'h77);
        tick();
        idle();
        check("clr_busyCount", {26'd0, rfBus.busyCount}, 32'd0);
        rfBus.rs1 = 5'd8;
        #1;
        check("clr_x8Busy",  {31'd0, rfBus.rs1Busy}, 32'd0);
        check("clr_x8Value", rfBus.rs1Value,         32'd0);
        rfBus.rs1 = 5'd5;
        #1;
        check("clr_x5Value", rfBus.rs1Value, 32'h11);
        check("clr_x6Value", rfBus.rs2Value, 32'h66);
        rfBus.rs1 = 5'd7;
        #1;
        check("clr_x7Value", rfBus.rs1Value, 32'h77);

        // same-cycle rename is not visible on the read port
        rfBus.rs1 = 5'd9;
        rename(5'd9, 4'd6);
        #1;
        check("noRenByp_busy", {31'd0, rfBus.rs1Busy}, 32'd0);
        tick();
        idle();
        check("x9_busy", {31'd0, rfBus.rs1Busy}, 32'd1);
        check("x9_dep",  {28'd0, rfBus.rs1Dep},  32'd6);

        // x0 ignores rename and commit
        rfBus.rs1 = 5'd0;
        rename(5'd0, 4'd1);
        commit(5'd0, 4'd1, 32'h55);
        #1;
        check("x0_sameBusy",  {31'd0, rfBus.rs1Busy}, 32'd0);
        check("x0_sameValue", rfBus.rs1Value,         32'd0);
        tick();
        idle();
        check("x0_busy",      {31'd0, rfBus.rs1Busy}, 32'd0);
        check("x0_value",     rfBus.rs1Value,         32'd0);
        check("x0_busyCount", {26'd0, rfBus.busyCount}, 32'd1);

        // asynchronous reset mid-run, sampled between edges
        rfBus.rs1 = 5'd9;
        rfBus.rs2 = 5'd5;
        #1;
        check("pre_rst_busy",  {31'd0, rfBus.rs1Busy}, 32'd1);
        check("pre_rst_value", rfBus.rs2Value,         32'h11);
        #1;
        resetIn = 1'b0;
        #1;
        check("arst_rs1Busy",   {31'd0, rfBus.rs1Busy}, 32'd0);
        check("arst_rs1Dep",    {28'd0, rfBus.rs1Dep},  32'd0);
        check("arst_rs2Value",  rfBus.rs2Value,         32'd0);
        check("arst_busyCount", {26'd0, rfBus.busyCount}, 32'd0);

        // inputs ignored while held in reset
        rename(5'd9, 4'd2);
        commit(5'd5, 4'd0, 32'hABCD);
        tick();
        check("inrst_busy",  {31'd0, rfBus.rs1Busy}, 32'd0);
        check("inrst_value", rfBus.rs2Value,         32'd0);
        idle();
        resetIn = 1'b1;
        tick();
        check("post_rst_busyCount", {26'd0, rfBus.busyCount}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: RegisterFile

Interface
REQ-001 SHALL have parameter ROB_WIDTH, default 4, meaning the width of a reorder-buffer tag.
REQ-002 SHALL have port clockIn  input  1  meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port resetIn  input  1  meaning the reset, asynchronous and active-low.
REQ-004 SHALL have port clear  input  1  meaning the mispredict flush from the reorder buffer.
REQ-005 SHALL have port commitValid  input  1  meaning a committed register write is present.
REQ-006 SHALL have port commitDest  input  5  meaning the commit destination register.
REQ-007 SHALL have port commitValue  input  32  meaning the commit data.
REQ-008 SHALL have port commitRobId  input  ROB_WIDTH  meaning the ROB tag of the committing entry.
REQ-009 SHALL have port renameValid  input  1  meaning an issued instruction claims a destination register.
REQ-010 SHALL have port renameDest  input  5  meaning the claimed destination register.
REQ-011 SHALL have port renameRobId  input  ROB_WIDTH  meaning the ROB tag of the issued instruction.
REQ-012 SHALL have ports rs1 / rs2  input  5  meaning the source register indices.
REQ-013 SHALL have ports rs1Busy / rs2Busy  output  1  meaning the source awaits a producer.
REQ-014 SHALL have ports rs1Dep / rs2Dep  output  ROB_WIDTH  meaning the producer ROB tag; valid only when busy.
REQ-015 SHALL have ports rs1Value / rs2Value  output  32  meaning the architectural value; valid only when not busy.
REQ-016 SHALL have port busyCount  output  6  meaning the number of registers currently busy.

Function
REQ-017 SHALL hold 32 entries of {value[31:0], busy, tag[ROB_WIDTH-1:0]}.
REQ-018 SHALL keep x0 with value 0 and busy 0 permanently; commits and renames to x0 are ignored.
REQ-019 SHALL, on commit (commitValid, dest != 0), write commitValue at the next edge.
REQ-020 SHALL, on that same edge, clear busy only if busy is set and tag == commitRobId; a younger tag stays busy.
REQ-021 SHALL, on rename (renameValid, dest != 0, !clear), set busy and tag = renameRobId at the next edge.
REQ-022 SHALL, when commit and rename hit the same register in one cycle, write the value and let rename win busy/tag.
REQ-023 SHALL, on clear, reset every busy bit at the next edge, retain all values, still apply a concurrent commit value write, and drop a concurrent rename.
REQ-024 SHALL drive the read ports combinationally from current state, with the following bypass: if commitValid, dest == rsN != 0, and the entry is busy with tag == commitRobId, then rsNBusy = 0 and rsNValue = commitValue.
REQ-025 SHALL NOT bypass a same-cycle rename to the read ports; the read reflects the pre-rename state.
REQ-026 SHALL register busyCount, equal to the popcount of busy[31:1] after each edge (range 0..31).

Reset
REQ-027 SHALL, while resetIn is 0 (asynchronously), clear all values, busy bits, tags and busyCount to 0.
REQ-028 SHALL ignore all commit/rename inputs during reset; the first update occurs on the first rising edge after release.
REQ-029 SHALL have, out of reset, every read port return busy 0, dep 0 and value 0.

Structure
REQ-030 SHALL take ROB_WIDTH, REG_COUNT = 32 and the ZERO_REG index from the shared CPU package.
REQ-031 SHALL instantiate sub-module RegisterReadPort twice (rs1, rs2); each implements the REQ-024 bypass mux.
REQ-032 SHALL contain no other sub-modules; state update is a single clocked process with asynchronous reset.

Verification
REQ-033 SHALL cover: rename x5 tag 3 -> next cycle rs1 = 5 gives busy 1, dep 3, busyCount 1.
REQ-034 SHALL cover: x5 busy tag 3, commit x5 tag 3 value 0xDEADBEEF -> same cycle rs1 busy 0, value 0xDEADBEEF; next cycle busyCount 0.
REQ-035 SHALL cover: x5 busy tag 7, commit x5 tag 3 value 0x11 -> value 0x11 stored, x5 still busy with dep 7.
REQ-036 SHALL cover: commit x6 tag 2 plus rename x6 tag 9 in the same cycle -> next cycle busy 1, dep 9, stored value = commit data.
REQ-037 SHALL cover: x1..x4 busy, assert clear together with rename x8 -> next cycle busyCount 0 and x8 not busy, values unchanged.
REQ-038 SHALL cover: rename and commit to x0 with value 0x55 -> rs1 = 0 reads busy 0, value 0; also drop resetIn mid-run -> all outputs 0 immediately, without waiting for a clock edge.
